// File: rtl/imem_boot_loader_pkg.sv
// imem_boot_loader_pkg: shared sizes, loader state encoding and error codes.
// Imported by the loader interface and the loader FSM.
package imem_boot_loader_pkg;

    localparam int DATA_LEN   = 32;
    localparam int I_MEM_SIZE = 1024;
    localparam int ADDR_W     = $clog2(I_MEM_SIZE);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LEN_LO  = 3'd1,
        S_LEN_HI  = 3'd2,
        S_PAYLOAD = 3'd3,
        S_CSUM    = 3'd4,
        S_RUN     = 3'd5,
        S_ERROR   = 3'd6
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE = 2'd0,
        ERR_LEN  = 2'd1,
        ERR_CSUM = 2'd2
    } err_e;

endpackage

// File: rtl/imem_boot_loader_if.sv
// imem_boot_loader_if: byte stream in (data/valid/ready) and I_MEM byte write port.
// slave = loader side, master = stream source / memory side.
interface imem_boot_loader_if;
    import imem_boot_loader_pkg::*;

    logic [7:0]        i_rx_data;
    logic              i_rx_valid;
    logic              o_rx_ready;
    logic              o_mem_we;
    logic [ADDR_W-1:0] o_mem_waddr;
    logic [7:0]        o_mem_wdata;

    modport slave (
        input  i_rx_data, i_rx_valid,
        output o_rx_ready, o_mem_we, o_mem_waddr, o_mem_wdata
    );

    modport master (
        output i_rx_data, i_rx_valid,
        input  o_rx_ready, o_mem_we, o_mem_waddr, o_mem_wdata
    );

endinterface

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: loads I_MEM from a length-prefixed, XOR-checked byte stream
// and holds the core in reset until the image is accepted.
// Ports: i_clk, i_rst_n (async, low), i_boot_en, i_reload, bus (stream + mem write),
//        o_cpu_rst_n, o_done, o_err (sticky), o_err_code.
module imem_boot_loader
    import imem_boot_loader_pkg::*;
(
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_boot_en,
    input  logic                      i_reload,
    imem_boot_loader_if.slave         bus,
    output logic                      o_cpu_rst_n,
    output logic                      o_done,
    output logic                      o_err,
    output logic [1:0]                o_err_code
);

    state_e            state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [ADDR_W:0]   wptr_q, wptr_d;
    logic [7:0]        csum_q, csum_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic              cpu_rst_n_q, cpu_rst_n_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    err_e              code_q, code_d;

    logic              rx_ready;
    logic              accept;
    logic              reload_hit;
    logic [15:0]       len_full;
    logic [ADDR_W:0]   wptr_inc;

    assign rx_ready = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                      (state_q == S_PAYLOAD) || (state_q == S_CSUM);
    assign accept     = bus.i_rx_valid && rx_ready;
    assign reload_hit = i_reload && (state_q != S_IDLE);
    assign len_full   = {bus.i_rx_data, len_q[7:0]};
    assign wptr_inc   = wptr_q + (ADDR_W+1)'(1);

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        wptr_d   = wptr_q;
        csum_d   = csum_q;
        mem_we_d = 1'b0;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        err_d    = err_q;
        code_d   = code_q;

        unique case (state_q)
            S_IDLE: begin
                state_d = i_boot_en ? S_LEN_LO : S_RUN;
            end
            S_LEN_LO: begin
                if (accept) begin
                    len_d[7:0] = bus.i_rx_data;
                    state_d    = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (accept) begin
                    len_d[15:8] = bus.i_rx_data;
                    if (len_full > 16'(I_MEM_SIZE)) begin
                        state_d = S_ERROR;
                        err_d   = 1'b1;
                        code_d  = ERR_LEN;
                    end else if (len_full == 16'd0) begin
                        state_d = S_CSUM;
                    end else begin
                        state_d = S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                if (accept) begin
                    mem_we_d = 1'b1;
                    waddr_d  = wptr_q[ADDR_W-1:0];
                    wdata_d  = bus.i_rx_data;
                    wptr_d   = wptr_inc;
                    csum_d   = csum_q ^ bus.i_rx_data;
                    if (16'(wptr_inc) == len_q) begin
                        state_d = S_CSUM;
                    end
                end
            end
            S_CSUM: begin
                if (accept) begin
                    if (bus.i_rx_data == csum_q) begin
                        state_d = S_RUN;
                    end else begin
                        state_d = S_ERROR;
                        err_d   = 1'b1;
                        code_d  = ERR_CSUM;
                    end
                end
            end
            S_RUN, S_ERROR: begin
                state_d = state_q;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Reload wins over a byte accepted in the same cycle.
        if (reload_hit) begin
            state_d  = S_LEN_LO;
            len_d    = '0;
            wptr_d   = '0;
            csum_d   = '0;
            mem_we_d = 1'b0;
            err_d    = 1'b0;
            code_d   = ERR_NONE;
        end

        cpu_rst_n_d = (state_q == S_RUN) && !reload_hit;
        done_d      = (state_q == S_RUN) && !reload_hit;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            wptr_q      <= '0;
            csum_q      <= '0;
            mem_we_q    <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            cpu_rst_n_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            code_q      <= ERR_NONE;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            wptr_q      <= wptr_d;
            csum_q      <= csum_d;
            mem_we_q    <= mem_we_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            cpu_rst_n_q <= cpu_rst_n_d;
            done_q      <= done_d;
            err_q       <= err_d;
            code_q      <= code_d;
        end
    end

    assign bus.o_rx_ready  = rx_ready;
    assign bus.o_mem_we    = mem_we_q;
    assign bus.o_mem_waddr = waddr_q;
    assign bus.o_mem_wdata = wdata_q;
    assign o_cpu_rst_n     = cpu_rst_n_q;
    assign o_done          = done_q;
    assign o_err           = err_q;
    assign o_err_code      = code_q;

endmodule
